// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receive controller.
// Optional parity stage is selected with macro SIPO_RX_PARITY_CHECK_EN.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit left shift register with shift enable and synchronous clear.
// New bits enter at the LSB, so the first bit shifted in ends up in the MSB.
module sipo_shift_en
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next shifter value: clear wins over shift.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], d};
    end
  end

  // Shifter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller for a serial-in/parallel-out datapath: gates the shifter
// per bit strobe, counts WIDTH bits, hands the word to a double-buffered
// output register with valid/ready, and flags dropped words as overrun.
// Macro SIPO_RX_PARITY_CHECK_EN adds a trailing parity bit per frame.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               parity_err_q, parity_err_d;

  logic [WIDTH-1:0]   sr_q;
  logic               sr_clr;
  logic               sr_en;
  logic               last_bit;
  logic               complete;
  logic [WIDTH-1:0]   word_in;
  logic               perr_in;

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst),
    .clr   (sr_clr),
    .en    (sr_en),
    .d     (ser_in),
    .q     (sr_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start aborts/restarts from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (start) begin
          state_d = SHIFT;
        end else if (ser_valid && last_bit) begin
`ifdef SIPO_RX_PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
      PARITY: begin
        if (start) begin
          state_d = SHIFT;
        end else if (ser_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: shifter control, frame completion and the offered word.
  always_comb begin
    busy     = (state_q != IDLE);
    sr_clr   = start;
    sr_en    = (state_q == SHIFT) && ser_valid && !start;
`ifdef SIPO_RX_PARITY_CHECK_EN
    complete = (state_q == PARITY) && ser_valid && !start;
    word_in  = sr_q;
    perr_in  = ((^sr_q) ^ ser_in) != ODD_PARITY;
`else
    complete = sr_en && last_bit;
    word_in  = {sr_q[WIDTH-2:0], ser_in};
    perr_in  = 1'b0;
`endif
  end

`ifndef SIPO_RX_PARITY_CHECK_EN
  // Without the parity stage the shifter MSB and parity sense are not needed.
  logic unused_bits;
  assign unused_bits = ODD_PARITY ^ sr_q[WIDTH-1];
`endif

  // Bit counter, output buffer and sticky overrun flag.
  always_comb begin
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    if (start) begin
      cnt_d = '0;
    end else if (sr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (ovr_clr) begin
      overrun_d = 1'b0;
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d   = word_in;
        parity_err_d = perr_in;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Testbench for sipo_rx_ctrl (WIDTH=4); exercises the parity stage when
// SIPO_RX_PARITY_CHECK_EN is defined.
module tb_sipo_rx_ctrl;

  localparam int unsigned W   = 4;
  localparam bit          ODD = 1'b0;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ser_valid;
  logic         ser_in;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
  logic         ovr_clr;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  // expected {parity_err, data}
  logic [W:0] exp_q[$];

  sipo_rx_ctrl #(
    .WIDTH      (W),
    .ODD_PARITY (ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ser_valid  (ser_valid),
    .ser_in     (ser_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .parity_err (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    tick();
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_valid_drop", out_valid, 0);
  endtask

  // One frame: start, data bits MSB first (plus parity bit when enabled).
  // The final strobe has no trailing gap; rdy is driven during that cycle.
  task automatic send(input logic [W-1:0] w, input logic flip, input logic rdy,
                      input logic noisy_start, input logic chk_lat);
    logic [W:0] bits;
    int n;
    start = 1'b1;
    if (noisy_start) begin
      ser_valid = 1'b1;
      ser_in    = 1'b1;
    end
    tick();
    start     = 1'b0;
    ser_valid = 1'b0;
`ifdef SIPO_RX_PARITY_CHECK_EN
    bits = {w, (^w) ^ ODD ^ flip};
    n = W + 1;
`else
    bits = {1'b0, w};
    n = W;
    if (flip) $display("note: parity flip ignored without parity stage");
`endif
    for (int i = n - 1; i >= 1; i--) strobe(bits[i]);
    if (chk_lat) check("latency_pre_valid", out_valid, 0);
    ser_valid = 1'b1;
    ser_in    = bits[0];
    out_ready = rdy;
    tick();
    ser_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Scoreboard monitor: every accepted word is compared with the queue head.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %b expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e[W-1:0]);
          check("sb_parity_err", parity_err, e[W]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    out_ready = 1'b0; ovr_clr = 1'b0;
    #12;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b1;
    tick();

    // Basic frame; strobe in IDLE and in the start cycle must be ignored.
    strobe(1'b1);
    check("idle_busy", busy, 0);
    exp_q.push_back({1'b0, 4'b1011});
    send(4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 4'b1011);
    check("basic_busy_done", busy, 0);
    repeat (3) tick();
    check("basic_valid_hold", out_valid, 1);
    consume();
    check("basic_data_kept", out_data, 4'b1011);

    // Overrun: second word dropped while first is pending.
    exp_q.push_back({1'b0, 4'b1011});
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_none_yet", overrun, 0);
    send(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_data_kept", out_data, 4'b1011);
    check("ovr_valid", out_valid, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Consume pending 1011 in the same cycle 0110 completes.
    exp_q.push_back({1'b0, 4'b0110});
    send(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    check("simul_data", out_data, 4'b0110);
    check("simul_valid", out_valid, 1);
    check("simul_overrun", overrun, 0);
    consume();

    // Restart: abort after two bits; restart cycle carries a strobe.
    exp_q.push_back({1'b0, 4'b0011});
    start = 1'b1;
    tick();
    start = 1'b0;
    strobe(1'b1);
    strobe(1'b1);
    check("restart_busy", busy, 1);
    send(4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_data", out_data, 4'b0011);
    check("restart_valid", out_valid, 1);
    check("restart_overrun", overrun, 0);
    check("restart_parity_err", parity_err, 0);
    consume();

`ifdef SIPO_RX_PARITY_CHECK_EN
    exp_q.push_back({1'b0, 4'b1011});
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_good", parity_err, 0);
    consume();
    exp_q.push_back({1'b1, 4'b1011});
    send(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_bad", parity_err, 1);
    check("par_bad_data", out_data, 4'b1011);
    consume();
`endif

    // Asynchronous reset in mid-frame with a word pending and overrun set.
    send(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_overrun", overrun, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    strobe(1'b1);
    strobe(1'b0);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_data", out_data, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_parity_err", parity_err, 0);
    tick();
    rst = 1'b1;
    tick();
    exp_q.push_back({1'b0, 4'b1001});
    send(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", out_data, 4'b1001);
    check("post_rst_valid", out_valid, 1);
    consume();

    repeat (5) tick();
    check("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Frame controller for a serial-in/parallel-out shift datapath.
- On each `start` pulse it gates the shifter with a per-bit strobe and counts WIDTH bits.
- It transfers the assembled word into a double-buffered output register with a valid/ready handshake, and flags overruns.
- Sits between a serial bit source (strobed) and a parallel word consumer.

Parameters:
- WIDTH, 4, data bits per frame (>= 2).
- ODD_PARITY, 0, parity sense when the parity feature is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  frame start pulse; sampled every cycle.
- ser_valid  input  1  bit strobe; ser_in is valid when this is 1.
- ser_in  input  1  serial data bit, MSB first.
- out_data  output  WIDTH  assembled word (registered).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  sticky: a completed word was dropped.
- ovr_clr  input  1  synchronous clear of overrun.
- parity_err  output  1  parity mismatch for the current out_data; qualified by out_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, shifter=0, bit count=0, out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0.
- Shifter update: sr <= {sr[WIDTH-2:0], ser_in}, only on accepted bits. The first bit received ends up in the MSB.
- Bit counter: width $clog2(WIDTH+1).
- IDLE:
  - start=1 -> SHIFT; clear sr and count.
  - ser_valid is ignored in IDLE and in the start cycle.
- SHIFT:
  - Each ser_valid=1 cycle shifts one bit and increments count.
  - On the ser_valid that delivers bit WIDTH, the frame completes: go to IDLE, or to PARITY if the feature is enabled.
  - Completion means {sr[WIDTH-2:0], ser_in} is offered to the output register in that same cycle.
- start=1 in SHIFT or PARITY: abort the frame and restart. Clear sr and count, stay or return to SHIFT. Bits already received are discarded and no flag is raised. start has priority over ser_valid in that cycle.
- Output register, evaluated at completion:
  - out_valid=0, or out_ready=1 in the same cycle: load the word; out_valid=1 from the next cycle.
  - out_valid=1 and out_ready=0: drop the new word, keep the old word, set overrun=1.
- Latency: out_valid rises one cycle after the final accepted bit.
- Consumption: out_valid && out_ready with no simultaneous completion -> out_valid=0 next cycle. out_data keeps its value.
- Double buffering: the next frame may shift while out_valid=1.
- overrun is sticky until ovr_clr=1. If a set and ovr_clr coincide, the set wins.
- busy=1 in SHIFT and PARITY.

Optional Feature:
- Macro: SIPO_RX_PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and waits for one more ser_valid bit.
  - Completion happens on the parity bit.
  - The parity error is computed as (^word ^ parity_bit) != ODD_PARITY.
  - It is loaded into parity_err together with out_data under the same overrun rules. The word is delivered regardless of the error.
- Undefined: no PARITY state exists, completion happens on bit WIDTH, and parity_err is tied to 0.

Decomposition:
- Package sipo_rx_pkg:
  - State encoding localparams: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10.
  - Counter-width function.
- Sub-module sipo_shift_en:
  - WIDTH-bit left shift register.
  - Inputs: shift enable, synchronous clear, async active-low reset.
  - Output: parallel q.
- The controller owns the FSM, counter, output register and flags.

Test Plan (WIDTH=4):
- Reset check: drive rst=0 after 2 bits of a frame -> all outputs 0 immediately, then busy=0. The next frame after reset is received cleanly.
- Basic frame: start, then bits 1,0,1,1 with idle gaps between strobes -> out_data=4'b1011.
  - out_valid=1 exactly one cycle after the 4th strobe.
  - out_valid holds until out_ready=1, then drops the next cycle.
- Overrun: with out_ready=0, frame 1011 followed by frame 0110 -> overrun=1 and out_data stays 1011. Then ovr_clr=1 -> overrun=0.
- Simultaneous consume and complete: out_ready=1 in the cycle frame 0110 completes while 1011 is pending -> out_data=0110, out_valid stays 1, overrun=0.
- Restart: start, bits 1,1, then start again, then bits 0,0,1,1 -> out_data=4'b0011 and no flags set.
- Parity (macro on, ODD_PARITY=0):
  - Bits 1011 + parity 1 -> parity_err=0.
  - Bits 1011 + parity 0 -> parity_err=1 with out_data=1011.
